acc_serial: RTL and testbench

ACC_SERIAL -- requirements
Module: acc_serial

---
 rtl/acc_serial_pkg.sv | 18 +
 rtl/acc_serial_full_add1.sv | 13 +
 rtl/acc_serial.sv | 101 ++++++++++
 tb/tb_acc_serial.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/acc_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and the counter-width helper.
package acc_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that walks 0..w-1; never narrower than one bit.
    function automatic int count_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/acc_serial_full_add1.sv
// One-bit full adder used as the single datapath cell of the serial accumulator.
module full_add1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/acc_serial.sv
// Bit-serial accumulator: adds each accepted operand into acc, LSB first,
// one bit per clock, and reports completion with a one-cycle sum_valid pulse.
module acc_serial
    import acc_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] sum,
    output logic             sum_valid,
    output logic             overflow
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] op_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             sum_valid_r;
    logic             in_ready_r;
    logic             sum_bit_s;
    logic             carry_s;

    full_add1 u_full_add1 (
        .a    (acc_r[0]),
        .b    (op_r[0]),
        .cin  (carry_r),
        .s    (sum_bit_s),
        .cout (carry_s)
    );

    // Control FSM and serial datapath; clear only has effect while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            acc_r       <= {WIDTH{1'b0}};
            op_r        <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            sum_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    sum_valid_r <= 1'b0;
                    if (clear) begin
                        acc_r      <= {WIDTH{1'b0}};
                        overflow_r <= 1'b0;
                    end
                    if (in_valid) begin
                        op_r       <= in_data;
                        carry_r    <= 1'b0;
                        count_r    <= {CW{1'b0}};
                        state_r    <= ADD;
                        in_ready_r <= 1'b0;
                    end
                end
                ADD: begin
                    acc_r   <= {sum_bit_s, acc_r[WIDTH-1:1]};
                    op_r    <= op_r >> 1;
                    carry_r <= carry_s;
                    count_r <= count_r + CW'(1);
                    // Result and carry-out are final on the last bit step.
                    if (count_r == LAST_COUNT) begin
                        state_r     <= DONE;
                        sum_valid_r <= 1'b1;
                        if (carry_s) begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    sum_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    sum_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign sum       = acc_r;
    assign sum_valid = sum_valid_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_acc_serial.sv
// Directed self-checking bench for acc_serial with a timeline-level reference model.
module tb_acc_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             clear;
    logic [WIDTH-1:0] sum;
    logic             sum_valid;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Reference model: result value and the time it becomes visible.
    int   m_acc;
    int   m_pend;
    int   m_busy;
    logic m_ovf;
    logic m_valid;
    int   m_accepts;

    acc_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .sum       (sum),
        .sum_valid (sum_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted operand occupies the block for WIDTH+2 cycles and
    // its modular sum appears WIDTH edges after acceptance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_acc     <= 0;
            m_pend    <= 0;
            m_busy    <= 0;
            m_ovf     <= 1'b0;
            m_valid   <= 1'b0;
            m_accepts <= 0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy == 0) begin
                if (clear) begin
                    m_acc <= 0;
                    m_ovf <= 1'b0;
                end
                if (in_valid) begin
                    m_pend    <= (clear ? 0 : m_acc) + int'(in_data);
                    m_busy    <= WIDTH + 1;
                    m_accepts <= m_accepts + 1;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 2) begin
                    m_acc   <= m_pend % 256;
                    m_valid <= 1'b1;
                    if (m_pend >= 256) m_ovf <= 1'b1;
                end
            end
        end
    end

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_in_ready", in_ready, (m_busy == 0) ? 1 : 0);
            chk("mon_sum_valid", sum_valid, m_valid);
            chk("mon_overflow", overflow, m_ovf);
            if (m_busy == 0 || m_valid) chk("mon_sum", sum, m_acc);
        end
    end

    task automatic run_op(input logic [7:0] d, input logic clr,
                          input logic [7:0] es, input logic eo, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_wait"}, (n < 50) ? 1 : 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = ~d;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (sum_valid) break;
        end
        chk({nm, "_latency"}, n, WIDTH);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_ovf"}, overflow, eo);
        @(posedge clk);
        #1;
        chk({nm, "_pulse_end"}, sum_valid, 0);
    endtask

    initial begin
        int acc_before;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear    = 1'b0;
        #2 rst = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        run_op(8'h05, 1'b0, 8'h05, 1'b0, "add05");
        run_op(8'h03, 1'b0, 8'h08, 1'b0, "add03");
        run_op(8'hF0, 1'b1, 8'hF0, 1'b0, "clr_addF0");
        run_op(8'h20, 1'b0, 8'h10, 1'b1, "add20_carry");
        run_op(8'h01, 1'b0, 8'h11, 1'b1, "add01_sticky");
        run_op(8'hFF, 1'b0, 8'h10, 1'b1, "addFF_wrap");
        run_op(8'h07, 1'b1, 8'h07, 1'b0, "clear_and_accept");
        run_op(8'hFF, 1'b1, 8'hFF, 1'b0, "clr_addFF");
        run_op(8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");

        // in_valid held high with in_data changing every cycle.
        @(negedge clk);
        acc_before = m_accepts;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream_accepts", m_accepts - acc_before, 3);
        chk("stream_sum", sum, 8'h1E);
        chk("stream_ovf", overflow, 1);

        // Reset during the fourth ADD cycle.
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum_valid", sum_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_sum", sum, 0);

        run_op(8'h09, 1'b0, 8'h09, 1'b0, "after_reset");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
